// File: rtl/mux2to1_2bit_arb.sv
// rtl/mux2to1_2bit_arb.sv - round-robin burst arbiter sharing a 2-bit 2:1 mux between requesters X and Y
module mux2to1_2bit_arb #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_x,
    input  logic [1:0] x,
    input  logic       req_y,
    input  logic [1:0] y,
    input  logic       ready,
    output logic       gnt_x,
    output logic       gnt_y,
    output logic       s,
    output logic [1:0] m,
    output logic       m_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_X = 2'd1,
        OWN_Y = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_y;
    logic             last_y_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             xfer_x;
    logic             xfer_y;
    logic             xfer;
    logic             burst_done;
    logic [1:0]       sel_data;

    // Grants decode straight from the state flops; select follows Y's grant.
    assign gnt_x = (state == OWN_X);
    assign gnt_y = (state == OWN_Y);
    assign s     = gnt_y;

    // A transfer happens only when the owner is requesting and the sink accepts.
    assign xfer_x     = gnt_x && req_x && ready;
    assign xfer_y     = gnt_y && req_y && ready;
    assign xfer       = xfer_x || xfer_y;
    assign cnt_inc    = cnt + CNT_W'(1);
    assign burst_done = xfer && (cnt_inc == CNT_W'(MAX_BURST));
    assign sel_data   = s ? y : x;

    // Arbitration and burst accounting; release hands over without a bubble.
    always_comb begin
        state_nxt  = state;
        last_y_nxt = last_y;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (req_x && (!req_y || last_y)) begin
                    state_nxt = OWN_X;
                    cnt_nxt   = '0;
                end else if (req_y) begin
                    state_nxt = OWN_Y;
                    cnt_nxt   = '0;
                end
            end
            OWN_X: begin
                if (xfer_x) begin
                    cnt_nxt = cnt_inc;
                end
                if (!req_x || burst_done) begin
                    last_y_nxt = 1'b0;
                    cnt_nxt    = '0;
                    if (req_y) begin
                        state_nxt = OWN_Y;
                    end else if (!burst_done) begin
                        state_nxt = IDLE;
                    end
                end
            end
            OWN_Y: begin
                if (xfer_y) begin
                    cnt_nxt = cnt_inc;
                end
                if (!req_y || burst_done) begin
                    last_y_nxt = 1'b1;
                    cnt_nxt    = '0;
                    if (req_x) begin
                        state_nxt = OWN_X;
                    end else if (!burst_done) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control state; last owner starts as Y so X wins the first contention.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            last_y <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            last_y <= last_y_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Output register slice: load on transfer, drain on ready, hold on backpressure.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m       <= 2'b00;
            m_valid <= 1'b0;
        end else if (xfer) begin
            m       <= sel_data;
            m_valid <= 1'b1;
        end else if (ready) begin
            m_valid <= 1'b0;
        end
    end

    // Grants must never overlap.
    assert property (@(posedge clock) disable iff (!resetn) !(gnt_x && gnt_y));

endmodule
